wbs_charlie_matrix: RTL and testbench
=====================================

Name: wbs_charlie_matrix

Overview:
Wishbone B4 pipelined slave that drives a charlieplexed LED matrix of ROWS x COLS pixels on COLS tri-state pins.
- Generalises the fixed 7x5 on/off driver: parametrised geometry, per-pixel PWM brightness, a control register and pixel readback.
- Sits on the peripheral Wishbone bus; pins go straight to top-level tri-state pads.
- One pixel is lit at a time. The scan visits every pixel in raster order, and each pixel dwells for one full PWM period.

Parameters:
WB_CLK_HZ, 12000000, bus clock frequency in Hz.
COLS, 7, matrix columns; also the pin count. Must be >= ROWS+1.
ROWS, 5, matrix rows. Must be >= 1.
BRIGHT_BITS, 4, per-pixel brightness width (1..8). BRIGHT_BITS=1 gives plain on/off.
SCAN_HZ, 100000, PWM period rate, i.e. pixels per second.

Ports:
wbs_clk_i  in  1  bus clock
wbs_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_adr_i  in  RB+CB+1  word address; RB=clog2(ROWS), CB=clog2(COLS)
wbs_dat_i  in  32  write data
wbs_dat_o  out  32  read data
wbs_stall_o  out  1  constant 0
wbs_ack_o  out  1  registered acknowledge
charlie_o  out  COLS  pin output values
charlie_oe  out  COLS  pin output enables (1 = driven)

Behaviour:
- Single clock wbs_clk_i. Reset wbs_rst_i is synchronous, active-high.
- Request: req = cyc & stb. stall is always 0.
- Acknowledge: ack is 1 exactly one cycle after every req cycle and 0 otherwise. ack is forced to 0 in the reset cycle.
- Address map:
  - adr MSB = 0: pixel register, adr = {row[RB-1:0], col[CB-1:0]}.
  - adr MSB = 1: CTRL register; lower bits are ignored.
- Pixel write:
  - Stores dat_i[BRIGHT_BITS-1:0] at the clock edge of the req cycle; the value is used by the scan from the next cycle.
  - Writes with row >= ROWS or col >= COLS are ignored but still acked.
  - Upper data bits are ignored.
- CTRL register:
  - bit0 ENABLE: reset value 1; when 0, charlie_o = charlie_oe = 0 and the scan keeps running.
  - bit1 CLEAR: write-1 strobe zeroes every pixel on that edge. CLEAR is not stored and reads as 0.
- Prescaler:
  - DIV = max(1, WB_CLK_HZ / (SCAN_HZ << BRIGHT_BITS)).
  - pre counts 0..DIV-1; tick = (pre == DIV-1).
  - On tick, pwm (BRIGHT_BITS wide) increments and wraps.
  - When pwm wraps from all-ones to 0, the cursor advances: col+1; at col == COLS-1, col goes to 0 and row goes to row+1; at row == ROWS-1, row goes to 0 (frame wrap).
  - Timing: pixel dwell = DIV << BRIGHT_BITS clocks; frame = ROWS*COLS dwells.
- Pin mapping:
  - col_pin = col.
  - row_pin = (row < col) ? row : row+1, so row_pin never equals col_pin.
- Lit condition: lit = ENABLE & (mem[row][col] > pwm).
  - Brightness 0 is always dark; brightness v has duty v / 2^BRIGHT_BITS.
- Pin outputs:
  - When lit: charlie_o = 1<<row_pin; charlie_oe = (1<<row_pin) | (1<<col_pin).
  - Otherwise both are 0.
  - Outputs are combinational from registered state; there are no glitches within a dwell apart from PWM edges.
- Simultaneous events:
  - A pixel write to the currently displayed pixel takes effect on the next cycle; mid-dwell changes are allowed.
  - CLEAR and a pixel write in the same cycle cannot occur (one req per cycle). CLEAR has priority over stored data.
- Reset, including mid-scan or mid-bus-cycle:
  - pre, pwm, row, col = 0; all pixels = 0; ENABLE = 1; ack = 0; dat_o = 0.
  - charlie_o = charlie_oe = 0 until a pixel is written.

Optional Feature:
WBS_CHARLIE_MATRIX_READBACK_EN
- Defined: dat_o is registered and valid alongside ack.
  - Pixel read returns the zero-extended brightness; out-of-range pixel addresses return 0.
  - CTRL read returns {30'b0, 1'b0, ENABLE}.
  - Write cycles return 0.
- Undefined: dat_o is constant 0; no read mux is synthesised.

Test Plan:
Defaults with WB_CLK_HZ=12800000 give DIV=8, dwell=128 clocks, frame=4480 clocks.
1. Reset, write pixel (row 0, col 1) = 15 -> during its dwell, charlie_o=7'b0000001 and charlie_oe=7'b0000011 for 120 of 128 clocks; all other dwells have pins at 0; ack pulses exactly 1 cycle after each stb.
2. Pixel (row 2, col 1) = 8 -> row_pin=3: charlie_oe=7'b0001010 for exactly 64 clocks per dwell, then 0 for 64 clocks; the pattern repeats every 4480 clocks.
3. Pixel (row 4, col 6) = 1 -> charlie_o=7'b0010000 for 8 clocks per frame; the frame wrap to (0,0) follows that dwell.
4. Write to adr row=5 (out of range) and CTRL=0 -> both acked; all pins stay 0 for a full frame. CTRL=1 then restores the previously lit pixels.
5. CTRL write bit1=1 after several pixels are set -> all pins stay 0 for the next full frame. With READBACK_EN, each pixel reads 0 and CTRL reads 1.
6. Assert wbs_rst_i mid-dwell while a req is pending -> next cycle ack=0, pins 0, row=col=pwm=0; reading (0,1) with READBACK_EN returns 0.

Source files
------------

// File: rtl/wbs_charlie_matrix_if.sv
//------------------------------------------------------------------------------
// Module   : wbs_charlie_matrix_if
// Brief    : Wishbone B4 pipelined bus bundle for the charlieplexed LED slave.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wbs_charlie_matrix_if #(
  parameter int ADR_W = 7
);
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [ADR_W-1:0] wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic [31:0]      wbs_dat_o;
  logic             wbs_stall_o;
  logic             wbs_ack_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_stall_o, wbs_ack_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_stall_o, wbs_ack_o
  );
endinterface

`default_nettype wire

// File: rtl/wbs_charlie_matrix.sv
//------------------------------------------------------------------------------
// Module   : wbs_charlie_matrix
// Brief    : Wishbone slave scanning a ROWS x COLS charlieplexed LED matrix with
//            per-pixel PWM. Optional WBS_CHARLIE_MATRIX_READBACK_EN adds reads.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wbs_charlie_matrix #(
  parameter int WB_CLK_HZ   = 12000000,
  parameter int COLS        = 7,
  parameter int ROWS        = 5,
  parameter int BRIGHT_BITS = 4,
  parameter int SCAN_HZ     = 100000
) (
  input  wire logic            wbs_clk_i,
  input  wire logic            wbs_rst_i,
  wbs_charlie_matrix_if.slave  wbs,
  output logic [COLS-1:0]      charlie_o,
  output logic [COLS-1:0]      charlie_oe
);

  // Row field is kept at least one bit wide so a single-row matrix still elaborates
  localparam int RB      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CB      = $clog2(COLS);
  localparam int AW      = RB + CB + 1;
  localparam int DIV_RAW = WB_CLK_HZ / (SCAN_HZ << BRIGHT_BITS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [RB:0]            ROWS_L   = ROWS[RB:0];
  localparam logic [CB:0]            COLS_L   = COLS[CB:0];
  localparam logic [RB-1:0]          ROW_LAST = RB'(ROWS - 1);
  localparam logic [CB-1:0]          COL_LAST = CB'(COLS - 1);
  localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [BRIGHT_BITS-1:0] PWM_LAST = '1;

  logic [BRIGHT_BITS-1:0] r_mem [ROWS][COLS];
  logic [PRE_W-1:0]       r_pre;
  logic [BRIGHT_BITS-1:0] r_pwm;
  logic [RB-1:0]          r_row;
  logic [CB-1:0]          r_col;
  logic                   r_enable;
  logic                   r_ack;

  logic          w_req;
  logic          w_ctrl_sel;
  logic [RB-1:0] w_adr_row;
  logic [CB-1:0] w_adr_col;
  logic          w_adr_hit;
  logic          w_pix_we;
  logic          w_ctrl_we;
  logic          w_clear;
  logic          w_tick;
  logic [CB-1:0] w_row_ext;
  logic [CB-1:0] w_row_pin;
  logic [COLS-1:0] w_row_bit;
  logic [COLS-1:0] w_col_bit;
  logic          w_lit;
  logic          w_unused_dat;

  assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_ctrl_sel = wbs.wbs_adr_i[AW-1];
  assign w_adr_row  = wbs.wbs_adr_i[CB +: RB];
  assign w_adr_col  = wbs.wbs_adr_i[0 +: CB];
  assign w_adr_hit  = ({1'b0, w_adr_row} < ROWS_L) && ({1'b0, w_adr_col} < COLS_L);
  assign w_pix_we   = w_req & wbs.wbs_we_i & ~w_ctrl_sel & w_adr_hit;
  assign w_ctrl_we  = w_req & wbs.wbs_we_i & w_ctrl_sel;
  assign w_clear    = w_ctrl_we & wbs.wbs_dat_i[1];
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_unused_dat = &{1'b0, wbs.wbs_dat_i};

  assign wbs.wbs_stall_o = 1'b0;
  assign wbs.wbs_ack_o   = r_ack;

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i || w_clear) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (w_pix_we) begin
      r_mem[w_adr_row][w_adr_col] <= wbs.wbs_dat_i[BRIGHT_BITS-1:0];
    end
  end

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_ack    <= 1'b0;
      r_enable <= 1'b1;
    end else begin
      r_ack <= w_req;
      if (w_ctrl_we) begin
        r_enable <= wbs.wbs_dat_i[0];
      end
    end
  end

  // Cursor advances only when the PWM counter rolls over, so each pixel gets a full period
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_pre <= '0;
      r_pwm <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_pwm <= r_pwm + 1'b1;
      if (r_pwm == PWM_LAST) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Skipping the column's own pin keeps anode and cathode on different pins
  assign w_row_ext = CB'(r_row);
  assign w_row_pin = (w_row_ext < r_col) ? w_row_ext : w_row_ext + 1'b1;
  assign w_row_bit = COLS'(1) << w_row_pin;
  assign w_col_bit = COLS'(1) << r_col;
  assign w_lit     = r_enable && (r_mem[r_row][r_col] > r_pwm);

  assign charlie_o  = w_lit ? w_row_bit : '0;
  assign charlie_oe = w_lit ? (w_row_bit | w_col_bit) : '0;

`ifdef WBS_CHARLIE_MATRIX_READBACK_EN
  logic [31:0] r_dat;

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_dat <= '0;
    end else if (w_req && !wbs.wbs_we_i) begin
      if (w_ctrl_sel) begin
        r_dat <= {31'b0, r_enable};
      end else if (w_adr_hit) begin
        r_dat <= 32'(r_mem[w_adr_row][w_adr_col]);
      end else begin
        r_dat <= '0;
      end
    end else begin
      r_dat <= '0;
    end
  end

  assign wbs.wbs_dat_o = r_dat;
`else
  assign wbs.wbs_dat_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wbs_charlie_matrix.sv
//------------------------------------------------------------------------------
// Module   : tb_wbs_charlie_matrix
// Brief    : Self-checking bench for wbs_charlie_matrix against a time-based model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wbs_charlie_matrix;

  localparam int COLS  = 7;
  localparam int ROWS  = 5;
  localparam int BB    = 4;
  localparam int DIV   = 8;
  localparam int DWELL = DIV << BB;
  localparam int NPIX  = ROWS * COLS;
  localparam int FRAME = NPIX * DWELL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbs_charlie_matrix_if #(.ADR_W(7)) bus_if ();
  logic [COLS-1:0] c_o;
  logic [COLS-1:0] c_oe;

  wbs_charlie_matrix #(
    .WB_CLK_HZ  (12800000),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .BRIGHT_BITS(BB),
    .SCAN_HZ    (100000)
  ) dut (
    .wbs_clk_i (clk),
    .wbs_rst_i (rst),
    .wbs       (bus_if),
    .charlie_o (c_o),
    .charlie_oe(c_oe)
  );

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    chk++;
    if (act !== req_v) begin
      err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
    end
  endtask

  // Reference model: time since reset determines the scan position directly
  int          m_t;
  logic [3:0]  m_mem [NPIX];
  bit          m_en;
  bit          m_ack;
  bit          m_valid = 1'b0;
  logic [31:0] m_dat;
  logic        req;
  assign req = bus_if.wbs_cyc_i & bus_if.wbs_stb_i;

  function automatic int pix_idx(input logic [6:0] a);
    int r = int'(a[5:3]);
    int c = int'(a[2:0]);
    if (r >= ROWS || c >= COLS) return -1;
    return r * COLS + c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t <= 0; m_en <= 1'b1; m_ack <= 1'b0; m_dat <= '0; m_valid <= 1'b1;
      for (int i = 0; i < NPIX; i++) m_mem[i] <= '0;
    end else begin
      m_t   <= m_t + 1;
      m_ack <= req;
      m_dat <= '0;
      if (req && bus_if.wbs_we_i) begin
        if (bus_if.wbs_adr_i[6]) begin
          m_en <= bus_if.wbs_dat_i[0];
          if (bus_if.wbs_dat_i[1]) for (int i = 0; i < NPIX; i++) m_mem[i] <= '0;
        end else if (pix_idx(bus_if.wbs_adr_i) >= 0) begin
          m_mem[pix_idx(bus_if.wbs_adr_i)] <= bus_if.wbs_dat_i[3:0];
        end
      end else if (req) begin
        if (bus_if.wbs_adr_i[6]) m_dat <= {31'b0, m_en};
        else if (pix_idx(bus_if.wbs_adr_i) >= 0) m_dat <= {28'b0, m_mem[pix_idx(bus_if.wbs_adr_i)]};
      end
    end
  end

  function automatic int cur_idx();
    return (m_t / DWELL) % NPIX;
  endfunction

  function automatic bit lit_now();
    int pwm = (m_t / DIV) % (1 << BB);
    return m_en && (int'(m_mem[cur_idx()]) > pwm);
  endfunction

  function automatic int row_pin();
    int r = cur_idx() / COLS;
    int c = cur_idx() % COLS;
    return (r < c) ? r : r + 1;
  endfunction

  function automatic logic [COLS-1:0] exp_o();
    return lit_now() ? COLS'(1 << row_pin()) : '0;
  endfunction

  function automatic logic [COLS-1:0] exp_oe();
    return lit_now() ? COLS'((1 << row_pin()) | (1 << (cur_idx() % COLS))) : '0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("ack", {31'b0, bus_if.wbs_ack_o}, {31'b0, m_ack});
      check("stall", {31'b0, bus_if.wbs_stall_o}, 32'd0);
      check("charlie_o", {25'b0, c_o}, {25'b0, exp_o()});
      check("charlie_oe", {25'b0, c_oe}, {25'b0, exp_oe()});
`ifdef WBS_CHARLIE_MATRIX_READBACK_EN
      if (m_ack) check("dat_o", bus_if.wbs_dat_o, m_dat);
`else
      check("dat_o_zero", bus_if.wbs_dat_o, 32'd0);
`endif
    end
  end

  task automatic bus(input bit we, input logic [6:0] adr, input logic [31:0] dat);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_dat_i = dat;
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame_count(input logic [6:0] eo, input logic [6:0] eoe,
                             output int lit, output int bad);
    lit = 0; bad = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (c_oe != '0) begin
        lit++;
        if (c_o != eo || c_oe != eoe) bad++;
      end
    end
  endtask

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [3:0] bright;
    logic [6:0] eo;
    logic [6:0] eoe;
    int         lit_clocks;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lit, bad;
    vecs[0] = '{3'd0, 3'd1, 4'd15, 7'b0000001, 7'b0000011, 120};
    vecs[1] = '{3'd2, 3'd1, 4'd8,  7'b0001000, 7'b0001010, 64};
    vecs[2] = '{3'd4, 3'd6, 4'd1,  7'b0010000, 7'b1010000, 8};
    vecs[3] = '{3'd1, 3'd0, 4'd3,  7'b0000100, 7'b0000101, 24};
    vecs[4] = '{3'd3, 3'd5, 4'd0,  7'b0000000, 7'b0000000, 0};

    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_adr_i = '0;
    bus_if.wbs_dat_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      bus(1'b1, {1'b0, vecs[i].row, vecs[i].col}, {28'($urandom), vecs[i].bright});
      frame_count(vecs[i].eo, vecs[i].eoe, lit, bad);
      check($sformatf("vec%0d_lit_clocks", i), lit, vecs[i].lit_clocks);
      check($sformatf("vec%0d_pattern", i), bad, 0);
    end

    // Out-of-range write plus disable, then re-enable
    do_reset();
    bus(1'b1, {1'b0, 3'd0, 3'd1}, 32'd15);
    bus(1'b1, {1'b0, 3'd5, 3'd2}, 32'd9);
    bus(1'b1, 7'h40, 32'd0);
    frame_count(7'b0000001, 7'b0000011, lit, bad);
    check("disabled_lit", lit, 0);
    bus(1'b1, 7'h40, 32'd1);
    frame_count(7'b0000001, 7'b0000011, lit, bad);
    check("reenabled_lit", lit, 120);
    check("reenabled_pattern", bad, 0);

    // CLEAR strobe wipes every pixel
    bus(1'b1, {1'b0, 3'd2, 3'd3}, 32'd7);
    bus(1'b1, {1'b0, 3'd4, 3'd6}, 32'd3);
    bus(1'b1, 7'h40, 32'd3);
    frame_count(7'b0, 7'b0, lit, bad);
    check("cleared_lit", lit, 0);
`ifdef WBS_CHARLIE_MATRIX_READBACK_EN
    for (int p = 0; p < NPIX; p++) begin
      bus(1'b0, {1'b0, 3'(p / COLS), 3'(p % COLS)}, 32'd0);
      check("rb_cleared_pixel", bus_if.wbs_dat_o, 32'd0);
    end
    bus(1'b0, 7'h7F, 32'd0);
    check("rb_ctrl", bus_if.wbs_dat_o, 32'd1);
`endif

    // Reset mid-dwell with a request pending
    do_reset();
    bus(1'b1, {1'b0, 3'd0, 3'd1}, 32'd15);
    repeat (150) @(negedge clk);
    check("pre_reset_oe", {25'b0, c_oe}, 32'b0000011);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_adr_i = {1'b0, 3'd0, 3'd1};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    check("rst_ack", {31'b0, bus_if.wbs_ack_o}, 32'd0);
    check("rst_oe", {25'b0, c_oe}, 32'd0);
`ifdef WBS_CHARLIE_MATRIX_READBACK_EN
    bus(1'b0, {1'b0, 3'd0, 3'd1}, 32'd0);
    check("rst_readback", bus_if.wbs_dat_o, 32'd0);
`endif
    repeat (300) @(negedge clk);

    // Randomized traffic; the per-cycle model comparison does the checking
    do_reset();
    repeat (2500) begin
      int k = $urandom_range(0, 9);
      if (k <= 5) bus(1'b1, {1'b0, 6'($urandom)}, $urandom);
      else if (k <= 7) bus(1'b0, 7'($urandom), $urandom);
      else if (k == 8) bus(1'b1, 7'h40 | 7'($urandom_range(0, 63)),
                           {30'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus(1'b1, 7'h40, 32'd1);
    repeat (FRAME) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

`default_nettype wire
